// File: rtl/add32_arbiter_seq_pkg.sv
// Shared definitions for the two-requester sequential 32-bit adder/subtractor.
package add32_arbiter_seq_pkg;

  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } grant_t;

  // A lone requester always wins; on a tie the round-robin pointer decides.
  function automatic grant_t pickGrant(input logic [1:0] valid, input logic ptr);
    grant_t g;
    g.valid = |valid;
    case (valid)
      2'b01:   g.id = 1'b0;
      2'b10:   g.id = 1'b1;
      2'b11:   g.id = ptr;
      default: g.id = 1'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/add32_arbiter_seq_cla16.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups feeding a group-level lookahead unit.
module CLA_16bit_2level
  import add32_arbiter_seq_pkg::*;
(
  input  logic [HALF_W-1:0] i_a,
  input  logic [HALF_W-1:0] i_b,
  input  logic              i_cin,
  output logic [HALF_W-1:0] o_sum,
  output logic              o_cout
);

  logic [HALF_W-1:0] w_g;
  logic [HALF_W-1:0] w_p;
  logic [HALF_W-1:0] w_c;
  logic [3:0]        w_grpG;
  logic [3:0]        w_grpP;
  logic [3:0]        w_grpC;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // First level: per-group generate/propagate and the carries inside each group.
  for (genvar k = 0; k < 4; k++) begin : gGroup
    localparam int B = 4 * k;
    assign w_grpG[k] = w_g[B+3]
                     | (w_p[B+3] & w_g[B+2])
                     | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                     | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_grpP[k] = &w_p[B+3:B];
    assign w_c[B]    = w_grpC[k];
    assign w_c[B+1]  = w_g[B] | (w_p[B] & w_grpC[k]);
    assign w_c[B+2]  = w_g[B+1]
                     | (w_p[B+1] & w_g[B])
                     | (w_p[B+1] & w_p[B] & w_grpC[k]);
    assign w_c[B+3]  = w_g[B+2]
                     | (w_p[B+2] & w_g[B+1])
                     | (w_p[B+2] & w_p[B+1] & w_g[B])
                     | (w_p[B+2] & w_p[B+1] & w_p[B] & w_grpC[k]);
  end

  // Second level: group carries computed directly from group G/P and the carry-in.
  assign w_grpC[0] = i_cin;
  assign w_grpC[1] = w_grpG[0] | (w_grpP[0] & i_cin);
  assign w_grpC[2] = w_grpG[1]
                   | (w_grpP[1] & w_grpG[0])
                   | (w_grpP[1] & w_grpP[0] & i_cin);
  assign w_grpC[3] = w_grpG[2]
                   | (w_grpP[2] & w_grpG[1])
                   | (w_grpP[2] & w_grpP[1] & w_grpG[0])
                   | (w_grpP[2] & w_grpP[1] & w_grpP[0] & i_cin);
  assign o_cout    = w_grpG[3]
                   | (w_grpP[3] & w_grpG[2])
                   | (w_grpP[3] & w_grpP[2] & w_grpG[1])
                   | (w_grpP[3] & w_grpP[2] & w_grpP[1] & w_grpG[0])
                   | (w_grpP[3] & w_grpP[2] & w_grpP[1] & w_grpP[0] & i_cin);

  assign o_sum = w_p ^ w_c;

endmodule

// File: rtl/add32_arbiter_seq.sv
// Two-requester round-robin front end for a 32-bit add/sub that reuses one 16-bit
// adder over two cycles (low half, then high half), holding the result until taken.
module add32_arbiter_seq
  import add32_arbiter_seq_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [1:0]        req_sub,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [DATA_W-1:0] res_sum,
  output logic              res_carry,
  output logic              res_ovf,
  output logic              busy
);

  state_t              r_state;
  logic                r_ptr;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_sub;
  logic                r_id;
  logic [HALF_W-1:0]   r_lowSum;
  logic                r_lowCarry;
  logic [DATA_W-1:0]   r_resSum;
  logic                r_resCarry;
  logic                r_resOvf;
  logic                r_resId;
  logic                r_resValid;
  logic                r_busy;

  grant_t              w_grant;
  logic [DATA_W-1:0]   w_bEff;
  logic [HALF_W-1:0]   w_addA;
  logic [HALF_W-1:0]   w_addB;
  logic                w_addCin;
  logic [HALF_W-1:0]   w_addSum;
  logic                w_addCout;

  assign w_grant = pickGrant(req_valid, r_ptr);

  // The grant is only offered while idle and out of reset.
  assign req_ready = (reset_n && (r_state == ST_IDLE) && w_grant.valid)
                   ? (w_grant.id ? 2'b10 : 2'b01) : 2'b00;

  // Subtraction is A + ~B + 1; the +1 enters as the low-half carry-in.
  assign w_bEff = r_sub ? ~r_b : r_b;

  // Steer the latched operand halves into the shared adder according to the phase.
  always_comb begin
    w_addA   = '0;
    w_addB   = '0;
    w_addCin = 1'b0;
    case (r_state)
      ST_LOW: begin
        w_addA   = r_a[HALF_W-1:0];
        w_addB   = w_bEff[HALF_W-1:0];
        w_addCin = r_sub;
      end
      ST_HIGH: begin
        w_addA   = r_a[DATA_W-1:HALF_W];
        w_addB   = w_bEff[DATA_W-1:HALF_W];
        w_addCin = r_lowCarry;
      end
      default: begin
        w_addA   = '0;
        w_addB   = '0;
        w_addCin = 1'b0;
      end
    endcase
  end

  CLA_16bit_2level uAdder (
    .i_a    (w_addA),
    .i_b    (w_addB),
    .i_cin  (w_addCin),
    .o_sum  (w_addSum),
    .o_cout (w_addCout)
  );

  // Arbitration, two-phase addition and result hand-off; reset drops any in-flight work.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= RR_INIT;
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_id       <= 1'b0;
      r_lowSum   <= '0;
      r_lowCarry <= 1'b0;
      r_resSum   <= '0;
      r_resCarry <= 1'b0;
      r_resOvf   <= 1'b0;
      r_resId    <= 1'b0;
      r_resValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant.valid) begin
            r_a     <= w_grant.id ? req_a1 : req_a0;
            r_b     <= w_grant.id ? req_b1 : req_b0;
            r_sub   <= req_sub[w_grant.id];
            r_id    <= w_grant.id;
            r_ptr   <= ~w_grant.id;
            r_busy  <= 1'b1;
            r_state <= ST_LOW;
          end
        end
        ST_LOW: begin
          r_lowSum   <= w_addSum;
          r_lowCarry <= w_addCout;
          r_state    <= ST_HIGH;
        end
        ST_HIGH: begin
          r_resSum   <= {w_addSum, r_lowSum};
          r_resCarry <= w_addCout;
          r_resOvf   <= (r_a[DATA_W-1] == w_bEff[DATA_W-1]) &
                        (w_addSum[HALF_W-1] != r_a[DATA_W-1]);
          r_resId    <= r_id;
          r_resValid <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign res_valid = r_resValid;
  assign res_id    = r_resId;
  assign res_sum   = r_resSum;
  assign res_carry = r_resCarry;
  assign res_ovf   = r_resOvf;
  assign busy      = r_busy;

endmodule

// File: tb/tb_add32_arbiter_seq.sv
// Testbench for add32_arbiter_seq: directed corner cases followed by random traffic,
// all checked against an arithmetic reference model and a round-robin pointer model.
module tb_add32_arbiter_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_sub;
  logic        res_valid;
  logic        res_ready;
  logic        res_id;
  logic [31:0] res_sum;
  logic        res_carry;
  logic        res_ovf;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;
  bit mPtr        = 1'b0;

  add32_arbiter_seq #(.RR_INIT(1'b0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Full-width arithmetic: carry is the 33rd bit (no-borrow for sub), overflow from signed range.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   output logic [31:0] sum, output logic c, output logic o);
    logic [32:0] u;
    longint      sa;
    longint      sb;
    longint      sr;
    sa = $signed(a);
    sb = $signed(b);
    if (s) begin
      u  = {1'b0, a} - {1'b0, b};
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b};
      c  = u[32];
      sr = sa + sb;
    end
    sum = u[31:0];
    o   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction from IDLE back to IDLE; called at a falling edge with the DUT idle.
  task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic [1:0] sub, input int stall);
    int          g;
    logic [31:0] ea, eb, eSum;
    logic        es, eC, eO;
    req_valid = valid;
    req_a0    = a0;
    req_b0    = b0;
    req_a1    = a1;
    req_b1    = b1;
    req_sub   = sub;
    res_ready = (stall == 0);
    #1;
    if (valid == 2'b01)      g = 0;
    else if (valid == 2'b10) g = 1;
    else if (valid == 2'b11) g = int'(mPtr);
    else                     g = -1;
    checkOutput("idleBusy", busy, 0);
    checkOutput("idleResValid", res_valid, 0);
    if (g < 0) begin
      checkOutput("noGrantReady", req_ready, 0);
      @(negedge clk);
      checkOutput("noGrantBusy", busy, 0);
      return;
    end
    checkOutput("grantReady", req_ready, (g == 1) ? 32'd2 : 32'd1);
    ea = (g == 1) ? a1 : a0;
    eb = (g == 1) ? b1 : b0;
    es = sub[g];
    refModel(ea, eb, es, eSum, eC, eO);
    mPtr = (g == 0);
    @(negedge clk);
    checkOutput("busyAfterAccept", busy, 1);
    checkOutput("readyWhileBusy", req_ready, 0);
    checkOutput("validEdge1", res_valid, 0);
    @(negedge clk);
    checkOutput("validEdge2", res_valid, 0);
    checkOutput("readyWhileBusy2", req_ready, 0);
    @(negedge clk);
    checkOutput("validEdge3", res_valid, 1);
    checkOutput("resSum", res_sum, eSum);
    checkOutput("resCarry", res_carry, eC);
    checkOutput("resOvf", res_ovf, eO);
    checkOutput("resId", res_id, g);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      checkOutput("stallValid", res_valid, 1);
      checkOutput("stallSum", res_sum, eSum);
      checkOutput("stallCarryOvf", {res_carry, res_ovf}, {eC, eO});
      checkOutput("stallId", res_id, g);
      checkOutput("stallReady", req_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("doneToIdleValid", res_valid, 0);
    checkOutput("doneToIdleBusy", busy, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_a0    = 32'h1234_5678;
    req_b0    = 32'h0000_0001;
    req_a1    = 32'h0000_0002;
    req_b1    = 32'h0000_0003;
    req_sub   = 2'b00;
    res_ready = 1'b0;

    // Reset state, with both requesters asserting to show no grant is offered.
    #2;
    checkOutput("rstReady", req_ready, 0);
    checkOutput("rstValid", res_valid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstSum", res_sum, 0);
    checkOutput("rstCarryOvfId", {res_carry, res_ovf, res_id}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mPtr    = 1'b0;

    // Directed arithmetic corners.
    applyStimulus(2'b01, 32'h0000_FFFF, 32'h0000_0001, 32'h0, 32'h0, 2'b00, 0);
    applyStimulus(2'b10, 32'h0, 32'h0, 32'h0000_0000, 32'h0000_0001, 2'b10, 0);
    applyStimulus(2'b10, 32'h0, 32'h0, 32'h0000_0005, 32'h0000_0003, 2'b10, 0);
    applyStimulus(2'b01, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h0, 2'b00, 1);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0, 2'b00, 0);
    applyStimulus(2'b10, 32'h0, 32'h0, 32'h0000_0000, 32'h8000_0000, 2'b10, 0);

    // Consumer holds off for five cycles while requesters keep asking.
    applyStimulus(2'b11, 32'hDEAD_BEEF, 32'h1111_1111, 32'hCAFE_F00D, 32'h2222_2222, 2'b01, 5);

    // No requests: nothing is granted and the pointer stays put.
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 0);
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 0);

    // Reset while the high half is being computed; requester 0 accepted first so the pointer moves to 1.
    req_valid = 2'b01;
    req_a0    = 32'h8000_0000;
    req_b0    = 32'h8000_0000;
    req_sub   = 2'b00;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstValid", res_valid, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstReady", req_ready, 0);
    checkOutput("midRstSum", res_sum, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mPtr    = 1'b0;

    // Both requesters held: grants alternate starting from requester 0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 0);
    end

    // Random traffic with occasional boundary operands and consumer stalls.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra0, rb0, ra1, rb1;
      ra0 = $urandom;
      rb0 = $urandom;
      ra1 = $urandom;
      rb1 = $urandom;
      if ($urandom_range(0, 3) == 0) ra0 = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) rb1 = 32'h8000_0000;
      applyStimulus(2'($urandom_range(0, 3)), ra0, rb0, ra1, rb1,
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/add32_arbiter_seq.md
ADD32_ARBITER_SEQ -- requirements
Module: add32_arbiter_seq

Interface
REQ-001 Parameter: RR_INIT, 0, round-robin priority pointer value after reset (0 = requester 0 first).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset; asynchronous and active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; bit i = requester i.
REQ-006 req_a0, req_b0  input  32 each  requester 0 operands.
REQ-007 req_a1, req_b1  input  32 each  requester 1 operands.
REQ-008 req_sub  input  2  per-requester op select; 1 = A-B, 0 = A+B.
REQ-009 res_valid  output  1  result valid.
REQ-010 res_ready  input  1  result consumer ready.
REQ-011 res_id  output  1  index of requester that owns the result.
REQ-012 res_sum  output  32  32-bit sum/difference.
REQ-013 res_carry  output  1  carry out of bit 31 (sub: 1 = no borrow).
REQ-014 res_ovf  output  1  signed two's-complement overflow.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, LOW, HIGH, DONE; single shared 16-bit adder performs every addition.
REQ-017 IDLE grant: one valid -> that requester; both valid -> requester equal to priority pointer; none -> no grant.
REQ-018 req_ready[i] = 1 only in IDLE when requester i is granted; otherwise 0 (combinational from state, req_valid and pointer).
REQ-019 On edge with req_valid[i] & req_ready[i]: latch a, b, sub, id=i; pointer <- other requester; state -> LOW.
REQ-020 LOW: adder in_0=a[15:0], in_1=sub ? ~b[15:0] : b[15:0], carry_in=sub; register low sum and carry; -> HIGH.
REQ-021 HIGH: adder in_0=a[31:16], in_1=sub ? ~b[31:16] : b[31:16], carry_in=registered low carry; register high sum, res_carry; -> DONE.
REQ-022 res_ovf = (a[31] == b_eff[31]) & (sum[31] != a[31]), b_eff = operand as applied to adder.
REQ-023 DONE: res_valid=1; res_sum/res_carry/res_ovf/res_id stable until res_valid & res_ready edge; then -> IDLE, res_valid=0.
REQ-024 Latency: accepting edge to res_valid high = 3 edges; minimum 4 cycles per transaction; no accept outside IDLE.
REQ-025 req_valid drop before acceptance: no effect, no pointer change; pointer advances only on acceptance.
REQ-026 res_ready high outside DONE ignored; res_ready in same cycle as res_valid rise completes in that cycle.

Reset
REQ-027 reset_n low at any time, including mid-transaction: state IDLE, in-flight operation discarded, pointer RR_INIT.
REQ-028 Reset values: res_valid 0, req_ready 0 while reset asserted, res_sum 0, res_carry 0, res_ovf 0, res_id 0, busy 0.

Structure
REQ-029 Shared package: state encoding (2-bit IDLE/LOW/HIGH/DONE), DATA_W=32, HALF_W=16.
REQ-030 Exactly one sub-module: one instance of CLA_16bit_2level as the shared adder; operand muxing, inversion and FSM in this module.

Verification
REQ-031 req0 add 0x0000FFFF + 0x00000001 -> res_sum 0x00010000, carry 0, ovf 0, res_id 0, res_valid 3 edges after accept.
REQ-032 req1 sub 0x00000000 - 0x00000001 -> res_sum 0xFFFFFFFF, carry 0, ovf 0, res_id 1; sub 5-3 -> 0x00000002, carry 1.
REQ-033 add 0x7FFFFFFF + 1 -> 0x80000000, ovf 1, carry 0; add 0xFFFFFFFF + 1 -> 0x00000000, carry 1, ovf 0.
REQ-034 Both req_valid held high, RR_INIT 0, res_ready 1 -> grant order 0,1,0,1; req_ready all-zero while busy.
REQ-035 res_ready low 5 cycles in DONE -> outputs stable, req_ready 0; res_ready high -> IDLE next edge, new grant possible.
REQ-036 reset_n low during HIGH -> res_valid 0, busy 0 immediately; after release first grant follows RR_INIT.
